// File: rtl/id_ex_stage.sv
// Decode/operand stage: drives register-file read addresses, bypasses write-back,
// decodes control, and holds the result in an ID/EX register with load-use stall.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc,
  output logic [REG_AW-1:0] RA,
  output logic [REG_AW-1:0] RB,
  input  logic [DATA_W-1:0] busA,
  input  logic [DATA_W-1:0] busB,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc,
  output logic [REG_AW-1:0] ex_rd,
  output logic [5:0]        ex_opcode,
  output logic [5:0]        ex_funct,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_illegal,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  function automatic logic [DATA_W-1:0] sel_opnd(
    input logic [REG_AW-1:0] addr,
    input logic [DATA_W-1:0] bus,
    input logic              we,
    input logic [REG_AW-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    if (addr == '0)                 return '0;
    else if (we && (waddr == addr)) return wdata;
    else                            return bus;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic signed [DATA_W-1:0] sext16(input logic signed [15:0] v);
    return DATA_W'(v);
  endfunction

  logic [5:0]               w_op;
  logic [REG_AW-1:0]        w_rd;
  logic                     w_rw, w_mr, w_mw, w_ill, w_rb_used;
  logic                     w_hazard;
  logic                     w_in_ready;
  logic [DATA_W-1:0]        w_a, w_b;
  logic signed [DATA_W-1:0] w_imm;

  logic                     r_vld_p1;
  logic [DATA_W-1:0]        r_a_p1, r_b_p1, r_imm_p1, r_pc_p1;
  logic [REG_AW-1:0]        r_rd_p1;
  logic [5:0]               r_op_p1, r_fn_p1;
  logic                     r_rw_p1, r_mr_p1, r_mw_p1, r_ill_p1;
  logic [CNT_W-1:0]         r_bubble_cnt;

  assign w_op  = instr[31:26];
  assign RA    = REG_AW'(instr[25:21]);
  assign RB    = REG_AW'(instr[20:16]);
  assign w_a   = sel_opnd(RA, busA, wb_en, wb_addr, wb_data);
  assign w_b   = sel_opnd(RB, busB, wb_en, wb_addr, wb_data);
  assign w_imm = sext16(instr[15:0]);

  always_comb begin
    w_rd      = '0;
    w_rw      = 1'b0;
    w_mr      = 1'b0;
    w_mw      = 1'b0;
    w_ill     = 1'b0;
    w_rb_used = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_rd      = REG_AW'(instr[15:11]);
        w_rw      = 1'b1;
        w_rb_used = 1'b1;
      end
      OP_ADDI: begin
        w_rd = REG_AW'(instr[20:16]);
        w_rw = 1'b1;
      end
      OP_LW: begin
        w_rd = REG_AW'(instr[20:16]);
        w_rw = 1'b1;
        w_mr = 1'b1;
      end
      OP_SW: begin
        w_mw      = 1'b1;
        w_rb_used = 1'b1;
      end
      OP_BEQ:  w_rb_used = 1'b1;
      default: w_ill     = 1'b1;
    endcase
  end

  // A load sitting in EX cannot yet supply its result to a dependent instruction
  assign w_hazard = r_vld_p1 && r_mr_p1 && (r_rd_p1 != '0) &&
                    ((r_rd_p1 == RA) || (w_rb_used && (r_rd_p1 == RB)));
  assign w_in_ready = flush ? 1'b1 : ((out_ready || !r_vld_p1) && !w_hazard);

  // ID -> EX boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1     <= 1'b0;
      r_a_p1       <= '0;
      r_b_p1       <= '0;
      r_imm_p1     <= '0;
      r_pc_p1      <= '0;
      r_rd_p1      <= '0;
      r_op_p1      <= '0;
      r_fn_p1      <= '0;
      r_rw_p1      <= 1'b0;
      r_mr_p1      <= 1'b0;
      r_mw_p1      <= 1'b0;
      r_ill_p1     <= 1'b0;
      r_bubble_cnt <= '0;
    end else if (flush) begin
      r_vld_p1 <= 1'b0;
    end else if (w_hazard && out_ready) begin
      r_vld_p1     <= 1'b0;
      r_bubble_cnt <= sat_inc(r_bubble_cnt);
    end else if (in_valid && w_in_ready) begin
      r_vld_p1 <= 1'b1;
      r_a_p1   <= w_a;
      r_b_p1   <= w_b;
      r_imm_p1 <= w_imm;
      r_pc_p1  <= pc;
      r_rd_p1  <= w_rd;
      r_op_p1  <= w_op;
      r_fn_p1  <= instr[5:0];
      r_rw_p1  <= w_rw;
      r_mr_p1  <= w_mr;
      r_mw_p1  <= w_mw;
      r_ill_p1 <= w_ill;
    end else if (out_ready && r_vld_p1) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = r_vld_p1;
  assign ex_a         = r_a_p1;
  assign ex_b         = r_b_p1;
  assign ex_imm       = r_imm_p1;
  assign ex_pc        = r_pc_p1;
  assign ex_rd        = r_rd_p1;
  assign ex_opcode    = r_op_p1;
  assign ex_funct     = r_fn_p1;
  assign ex_reg_write = r_rw_p1;
  assign ex_mem_read  = r_mr_p1;
  assign ex_mem_write = r_mw_p1;
  assign ex_illegal   = r_ill_p1;
  assign bubble_cnt   = r_bubble_cnt;

endmodule
